// File: rtl/lcd12864_ctrl.sv
`timescale 1ns/1ps
// lcd12864_ctrl: ST7920 128x64 parallel-mode controller that initialises the panel and rewrites
// LINES x 16 characters from an external text buffer; LCD12864_AUTO_REFRESH_EN adds a periodic refresh.
module lcd12864_ctrl #(
   parameter int PWRUP_CYC   = 2_500_000,
   parameter int STEP_CYC    = 4_000,
   parameter int CLR_CYC     = 80_000,
   parameter int LINES       = 4,
   parameter int REFRESH_CYC = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       refresh,
   input  logic [7:0] char_data,
   output logic [5:0] char_addr,
   output logic       busy,
   output logic       done,
   output logic       RS,
   output logic       RW,
   output logic       EN,
   output logic       PSB,
   output logic [7:0] DB
);
   typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETADDR, WRDATA, DONE} state_t;
   state_t      state;
   logic [31:0] cnt, n, cnt_nx;
   logic [1:0]  idx, line;
   logic [3:0]  col;
   logic        pending, req, last, en_nx, auto_tick;

   assign RW  = 1'b0;
   assign PSB = 1'b1;

   function automatic logic [7:0] cmd(input logic [1:0] i);
      return i == 2'd0 ? 8'h30 : i == 2'd1 ? 8'h0C : i == 2'd2 ? 8'h01 : 8'h06;
   endfunction

   // DDRAM line starts interleave: 0x80, 0x90, 0x88, 0x98
   function automatic logic [7:0] line_addr(input logic [1:0] l);
      return {1'b1, 2'b00, l[0], l[1], 3'b000};
   endfunction

`ifdef LCD12864_AUTO_REFRESH_EN
   logic [31:0] ref_cnt;
   always_ff @(posedge clk)
      if (!rst_n) ref_cnt <= '0;
      else ref_cnt <= auto_tick ? '0 : ref_cnt + 32'd1;
   assign auto_tick = ref_cnt == 32'(REFRESH_CYC - 1);
`else
   assign auto_tick = 1'b0 & (REFRESH_CYC != 0);
`endif

   always_comb begin
      n      = (state == INIT && idx == 2'd2) ? 32'(CLR_CYC) : 32'(STEP_CYC);
      last   = (state == PWRUP) ? cnt == 32'(PWRUP_CYC - 1) : cnt == n - 32'd1;
      cnt_nx = last ? '0 : cnt + 32'd1;
      en_nx  = (state == INIT || state == SETADDR || state == WRDATA) && !last &&
               cnt_nx >= n / 32'd4 && cnt_nx < (32'd3 * n) / 32'd4;
      req    = refresh | auto_tick;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= PWRUP;
         cnt       <= '0;
         idx       <= '0;
         line      <= '0;
         col       <= '0;
         pending   <= 1'b0;
         EN        <= 1'b0;
         RS        <= 1'b0;
         DB        <= 8'h00;
         char_addr <= '0;
         busy      <= 1'b1;
         done      <= 1'b0;
      end else begin
         cnt  <= cnt_nx;
         EN   <= en_nx;
         done <= 1'b0;
         if (req && state != IDLE) pending <= 1'b1;
         case (state)
            PWRUP: if (last) begin
               state <= INIT;
               idx   <= 2'd0;
               DB    <= cmd(2'd0);
               RS    <= 1'b0;
            end
            INIT: if (last) begin
               if (idx == 2'd3) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  idx <= idx + 2'd1;
                  DB  <= cmd(idx + 2'd1);
               end
            end
            IDLE: begin
               cnt <= '0;
               if (req || pending) begin
                  state   <= SETADDR;
                  busy    <= 1'b1;
                  pending <= 1'b0;
                  line    <= 2'd0;
                  col     <= 4'd0;
                  RS      <= 1'b0;
                  DB      <= line_addr(2'd0);
               end
            end
            SETADDR: if (last) begin
               state     <= WRDATA;
               RS        <= 1'b1;
               char_addr <= {line, col};
            end
            WRDATA: begin
               // buffer data is taken two cycles after the address goes out
               if (cnt == 32'd2) DB <= char_data;
               if (last) begin
                  col <= col + 4'd1;
                  if (col != 4'd15) char_addr <= {line, col + 4'd1};
                  else if (line == 2'(LINES - 1)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= SETADDR;
                     line  <= line + 2'd1;
                     RS    <= 1'b0;
                     DB    <= line_addr(line + 2'd1);
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= PWRUP;
         endcase
      end
   end
endmodule

// File: doc/lcd12864_ctrl.md
LCD12864_CTRL -- requirements
Module: lcd12864_ctrl

Interface
REQ-001 SHALL provide parameter PWRUP_CYC, default 2_500_000, meaning the power-up wait before the first command (50 ms at 50 MHz).
REQ-002 SHALL provide parameter STEP_CYC, default 4_000, meaning the clk cycles per normal command/data transaction (80 us).
REQ-003 SHALL provide parameter CLR_CYC, default 80_000, meaning the clk cycles for the clear-display (0x01) transaction (1.6 ms).
REQ-004 SHALL provide parameter LINES, default 4, range 1..4, meaning the number of display lines refreshed.
REQ-005 SHALL provide parameter REFRESH_CYC, default 50_000_000, meaning the auto-refresh interval; it is used only under LCD12864_AUTO_REFRESH_EN.
REQ-006 SHALL have port clk, input, 1 bit: the single system clock.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, which is synchronous and active-low.
REQ-008 SHALL have port refresh, input, 1 bit: a one-cycle pulse requesting a full screen rewrite.
REQ-009 SHALL have port char_data, input, 8 bits: the byte from the external text buffer at char_addr.
REQ-010 SHALL have port char_addr, output, 6 bits: the text buffer address, equal to line*16+col.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the controller is not in IDLE.
REQ-012 SHALL have port done, output, 1 bit: a one-cycle pulse after the last byte of a refresh.
REQ-013 SHALL have ports RS, RW, EN and PSB, output, 1 bit each: ST7920 control lines.
REQ-014 SHALL have port DB, output, 8 bits: the ST7920 parallel data bus.

Function
REQ-015 SHALL tie RW to 0 (write only) and PSB to 1 (parallel mode) at all times.
REQ-016 SHALL implement FSM states PWRUP -> INIT -> IDLE -> SETADDR -> WRDATA -> (SETADDR for the next line, or DONE) -> IDLE.
REQ-017 SHALL stay in PWRUP for exactly PWRUP_CYC cycles with EN=0.
REQ-018 SHALL have INIT issue the commands 0x30, 0x0C, 0x01, 0x06 in order, one transaction each, with RS=0.
REQ-019 SHALL time each transaction with a step counter 0..N-1, where N=CLR_CYC for 0x01 and N=STEP_CYC otherwise.
REQ-020 SHALL drive DB/RS from counter 0 to N-1, and SHALL drive EN=1 only for counter values in [N/4, 3N/4).
REQ-021 SHALL have SETADDR issue the line address with RS=0: line0=0x80, line1=0x90, line2=0x88, line3=0x98.
REQ-022 SHALL have WRDATA issue 16 data transactions per line with RS=1 and col 0..15.
REQ-023 SHALL set char_addr at counter 0, and SHALL load DB from char_data at counter 2 (external buffer read latency ≤2 cycles).
REQ-024 SHALL, after col 15 of line LINES-1, enter DONE, pulse done for 1 cycle, and return to IDLE.
REQ-025 SHALL perform one refresh totalling LINES*17 transactions.
REQ-026 SHALL start a refresh when refresh is sampled high in IDLE, entering SETADDR on the next cycle.
REQ-027 SHALL latch refresh into a pending flag while busy, and SHALL start exactly one further refresh on the IDLE return, however many pulses arrived.
REQ-028 SHALL latch a refresh arriving in PWRUP/INIT as pending.
REQ-029 SHALL, when refresh arrives in the same cycle as done, set pending.
REQ-030 SHALL have the col counter wrap from 15 to 0 with a line increment, and the line counter SHALL NOT exceed LINES-1.

Reset
REQ-031 SHALL, while rst_n=0 at a clk edge, set state=PWRUP, counters=0, pending=0, EN=0, RS=0, DB=0x00, char_addr=0, busy=1, done=0.
REQ-032 SHALL, on reset assertion mid-transaction, force EN low on the next edge, discard the transaction, and restart from PWRUP.

Configuration
REQ-033 SHALL, with LCD12864_AUTO_REFRESH_EN defined, set pending automatically every REFRESH_CYC cycles (free-running counter cleared by reset), in addition to the refresh input.
REQ-034 SHALL, without LCD12864_AUTO_REFRESH_EN, omit that counter, so refreshes occur only via the refresh input.

Verification (PWRUP_CYC=16, STEP_CYC=8, CLR_CYC=32, LINES=4)
REQ-035 SHALL verify: release reset, no refresh -> EN=0 for 16 cycles, then DB 0x30,0x0C,0x01,0x06 with RS=0; the 0x01 EN pulse lasts 16 cycles, the others 4; then busy=0.
REQ-036 SHALL verify: refresh pulse in IDLE, buffer char_data=addr+0x40 -> 68 EN pulses; DB sequence 0x80, 0x40..0x4F, 0x90, 0x50..0x5F, 0x88, 0x60..0x6F, 0x98, 0x70..0x7F; one done pulse.
REQ-037 SHALL verify: three refresh pulses during an active refresh -> exactly two refreshes total (136 transactions), two done pulses.
REQ-038 SHALL verify: rst_n low for 1 cycle while EN=1 in line 2 -> EN=0, DB=0x00 next edge; the PWRUP/INIT sequence repeats; no done pulse.
REQ-039 SHALL verify: LINES=2 -> 34 transactions, last address command 0x90, done after byte 31.
REQ-040 SHALL verify: LCD12864_AUTO_REFRESH_EN with REFRESH_CYC=2000, no refresh input -> a refresh starts every 2000 cycles; undefined -> none.
